// File: rtl/uart_pkg.sv
// Shared UART types and defaults: receiver state encoding and oversample ratio.
`timescale 1ns/1ps
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial-in / word-out bundle between the sample strobe source, the line and the byte consumer.
`timescale 1ns/1ps
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 sample_en;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  sample_en, rx,
    output rx_data, rx_valid, parity_err, frame_err, busy
  );

  modport slave (
    output sample_en, rx,
    input  rx_data, rx_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the async serial line plus rising-edge detect on the oversample strobe.
`timescale 1ns/1ps
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic rx,
  output logic rx_s,
  output logic tick
);

  logic rx_m;
  logic sample_en_d;

  // Delay flop resets high so a strobe already asserted at reset release is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      sample_en_d <= 1'b1;
    end else begin
      rx_m        <= rx;
      rx_s        <= rx_m;
      sample_en_d <= sample_en;
    end
  end

  assign tick = sample_en & ~sample_en_d;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/parity/stop framing rebuilt into parallel words.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.master bus
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] MID_CNT  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST_CNT = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t            state;
  logic [SW-1:0]        smp_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 perr;
  logic                 rx_s;
  logic                 tick;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .sample_en (bus.sample_en),
    .rx        (bus.rx),
    .rx_s      (rx_s),
    .tick      (tick)
  );

  // Framing FSM; advances only on sample ticks, pulses last exactly one clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      smp_cnt        <= '0;
      bit_cnt        <= '0;
      shift          <= '0;
      perr           <= 1'b0;
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              smp_cnt  <= '0;
              bus.busy <= 1'b1;
            end
          end
          START: begin
            if (smp_cnt == MID_CNT) begin
              smp_cnt <= '0;
              bit_cnt <= '0;
              if (rx_s) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              smp_cnt <= smp_cnt + SW'(1);
            end
          end
          DATA: begin
            if (smp_cnt == LAST_CNT) begin
              smp_cnt <= '0;
              shift   <= {rx_s, shift[DATA_BITS-1:1]};
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                state   <= (PARITY_EN != 0) ? PARITY : STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              smp_cnt <= smp_cnt + SW'(1);
            end
          end
          PARITY: begin
            if (smp_cnt == LAST_CNT) begin
              smp_cnt <= '0;
              perr    <= ((^shift) ^ rx_s) != 1'(PARITY_ODD);
              state   <= STOP;
            end else begin
              smp_cnt <= smp_cnt + SW'(1);
            end
          end
          STOP: begin
            if (smp_cnt == LAST_CNT) begin
              smp_cnt <= '0;
              if (rx_s) begin
                bus.rx_valid   <= 1'b1;
                bus.rx_data    <= shift;
                bus.parity_err <= (PARITY_EN != 0) ? perr : 1'b0;
                bus.busy       <= 1'b0;
                state          <= IDLE;
              end else begin
                bus.frame_err <= 1'b1;
                state         <= BREAK;
              end
            end else begin
              smp_cnt <= smp_cnt + SW'(1);
            end
          end
          BREAK: begin
            // Line must return high before another start bit can be accepted.
            if (rx_s) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
